eh2_dec_gpr_wb_queue: RTL
=========================

// Module: eh2_dec_gpr_wb_queue
// PURPOSE
// - Write-side feeder for one GPR-file write port (wen/wtid/waddr/wd).
// - Buffers out-of-pipe writebacks (divider, non-blocking load) in an in-order FIFO.
// - Drains one entry per cycle whenever the pipe leaves the port idle.
// - Exports per-thread pending-write masks so decode can stall on hazards.
// PARAMETERS
// - DEPTH  4  FIFO entries; power of 2, >=2.
// PORTS
// clk            in   1   core clock
// rst            in   1   synchronous, active-high reset
// nb_valid       in   1   non-blocking load writeback request
// nb_tid         in   1   thread of nb request
// nb_addr        in   5   destination GPR
// nb_data        in   32  writeback data
// nb_ready       out  1   nb request accepted this cycle when nb_valid&nb_ready
// div_valid      in   1   divider writeback request
// div_tid        in   1   thread of div request
// div_addr       in   5   destination GPR
// div_data       in   32  writeback data
// div_ready      out  1   div request accepted when div_valid&div_ready
// port_busy      in   1   pipe owns the GPR write port this cycle
// flush_valid    in   1   kill queued writes of one thread
// flush_tid      in   1   thread being flushed
// wen            out  1   GPR write enable
// wtid           out  1   GPR write thread
// waddr          out  5   GPR write address
// wd             out  32  GPR write data
// pend_t0        out  31  [31:1] GPRs with a live queued write, thread 0
// pend_t1        out  31  [31:1] same, thread 1
// BEHAVIOUR
// - Reset: wr/rd pointers=0, count=0, all entry live bits=0; wen=0, pend_t*=0; nb_ready=div_ready=0 while rst.
// - Entry = {live, tid, addr[4:0], data[31:0]}; pointers wrap modulo DEPTH; count in 0..DEPTH.
// - Ready: nb_ready=(free>=1); div_ready=(free>=2); free=DEPTH-count (registered, not dependent on *_valid).
// - Enqueue order, both accepted in one cycle: nb entry first, then div.
// - addr==0 requests: handshake completes, nothing enqueued, no write.
// - Drain: head live & ~port_busy -> wen=1, wtid/waddr/wd=head; pop at clock edge.
// - Head dead (flushed): popped without wen, port_busy ignored; one entry per cycle.
// - Outputs combinational from head: request accepted at edge N, earliest wen in cycle N+1.
// - port_busy=1: wen=0, head held; no data loss.
// - Push and pop in the same cycle are legal; count unchanged for 1 push + 1 pop.
// - At count==DEPTH-1, only nb can be accepted.
// - flush_valid: every live entry with tid==flush_tid cleared at the edge, incl. same-cycle pushes of that tid.
// - On flush: wen of a flushed head is still suppressed in that cycle (flush applied before drain).
// - pend_t0/t1: OR of one-hot addr decode over live entries per tid; includes head until popped.
// - Ordering: writes to the same GPR/tid reach wen in acceptance order.
// - Reset mid-operation: queue contents discarded, no wen in the reset cycle or the cycle after.
// - RV_ASSERT_ON: assert no push when count==DEPTH.
// CONFIGURATION
// - RV_GPR_WB_BYPASS_EN defined: when count==0, ~port_busy, no flush of the same tid:
//   - accepted nb (else div) drives wen in the same cycle, not enqueued; zero latency.
//   - if both are valid, div is enqueued.
// - RV_GPR_WB_BYPASS_EN undefined: all writes pass through the FIFO; min latency 1 cycle.
// TESTING
// - nb(t0,x5,0xA5A5_0001), port idle -> wen cycle N+1, waddr=5, wd=0xA5A5_0001; pend_t0[5]=1 for one cycle.
// - nb+div same cycle (t1,x3 / t1,x7), port_busy=1 for 3 cycles -> x3 then x7 written on consecutive cycles after release.
// - Fill DEPTH=4 with port_busy=1 -> nb_ready=0 at count 4, div_ready=0 at count 3; no overflow assert.
// - Queue {t0 x1, t1 x2, t0 x3}, flush_tid=0 -> only t1 x2 written; pend_t0=0 the cycle after flush.
// - nb addr=0 -> accepted, count stays 0, wen never asserts.
// - BYPASS_EN: empty queue, nb(t0,x9,0x1234), port idle -> wen same cycle, count stays 0; undefined -> wen next cycle.

Source files
------------

// File: rtl/eh2_dec_gpr_wb_queue_if.sv
// eh2_dec_gpr_wb_queue_if
//   Bundles the request, flush and GPR write-port signals of the
//   writeback queue. clk/rst are plain module ports and are not part of it.
//
//   master : request producers / pipe side (drives requests, busy, flush;
//            observes ready, write port and pending masks)
//   slave  : the writeback queue itself
//
//   nb_*      non-blocking load writeback request (valid/tid/addr/data, ready)
//   div_*     divider writeback request (valid/tid/addr/data, ready)
//   port_busy pipe owns the GPR write port this cycle
//   flush_*   kill queued writes of one thread
//   wen/wtid/waddr/wd  GPR write port
//   pend_t0/pend_t1    GPRs [31:1] with a live queued write, per thread
interface eh2_dec_gpr_wb_queue_if;
    logic        nb_valid;
    logic        nb_tid;
    logic [4:0]  nb_addr;
    logic [31:0] nb_data;
    logic        nb_ready;

    logic        div_valid;
    logic        div_tid;
    logic [4:0]  div_addr;
    logic [31:0] div_data;
    logic        div_ready;

    logic        port_busy;
    logic        flush_valid;
    logic        flush_tid;

    logic        wen;
    logic        wtid;
    logic [4:0]  waddr;
    logic [31:0] wd;

    logic [31:1] pend_t0;
    logic [31:1] pend_t1;

    modport master (
        output nb_valid, nb_tid, nb_addr, nb_data,
        input  nb_ready,
        output div_valid, div_tid, div_addr, div_data,
        input  div_ready,
        output port_busy, flush_valid, flush_tid,
        input  wen, wtid, waddr, wd,
        input  pend_t0, pend_t1
    );

    modport slave (
        input  nb_valid, nb_tid, nb_addr, nb_data,
        output nb_ready,
        input  div_valid, div_tid, div_addr, div_data,
        output div_ready,
        input  port_busy, flush_valid, flush_tid,
        output wen, wtid, waddr, wd,
        output pend_t0, pend_t1
    );
endinterface

// File: rtl/eh2_dec_gpr_wb_queue.sv
// eh2_dec_gpr_wb_queue
//   Write-side feeder for one GPR-file write port. Out-of-pipe writebacks
//   (non-blocking loads, divider) are buffered in an in-order FIFO and
//   drained one entry per cycle whenever the pipe leaves the port idle.
//   Per-thread pending-write masks let decode stall on hazards.
//
// Ports
//   clk   core clock
//   rst   synchronous, active-high reset
//   bus   eh2_dec_gpr_wb_queue_if.slave (requests, flush, write port, masks)
//
// Parameters
//   DEPTH  FIFO entries, power of 2, >= 2
//
// Configuration macros
//   RV_GPR_WB_BYPASS_EN  when defined, a request arriving at an empty queue
//                        with the port idle is written in the same cycle
//                        instead of being enqueued.
//   RV_ASSERT_ON         enables the overflow assertion.
module eh2_dec_gpr_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    eh2_dec_gpr_wb_queue_if.slave     bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [DEPTH-1:0] ent_live;
    logic [DEPTH-1:0] ent_tid;
    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [CNT_W-1:0] count;

    logic q_empty;
    logic nb_ready_int;
    logic div_ready_int;
    logic nb_acc;
    logic div_acc;
    logic nb_flush_hit;
    logic div_flush_hit;
    logic head_flush_hit;
    logic head_eff;
    logic drain_wen;
    logic pop;
    logic byp_nb;
    logic byp_div;
    logic push_nb;
    logic push_div;
    ptr_t nb_slot;
    ptr_t div_slot;

    logic        wen_c;
    logic        wtid_c;
    logic [4:0]  waddr_c;
    logic [31:0] wd_c;
    logic [31:1] pend0_c;
    logic [31:1] pend1_c;

    assign q_empty = (count == '0);

    // Ready comes only from the registered occupancy, so it never depends on
    // this cycle's valids or pops. div needs two free slots so nb always has
    // room when both arrive together.
    assign nb_ready_int  = ~rst & (count <  CNT_W'(DEPTH));
    assign div_ready_int = ~rst & (count <= CNT_W'(DEPTH - 2));

    // addr 0 requests complete the handshake but never occupy the queue.
    assign nb_acc  = bus.nb_valid  & nb_ready_int  & (bus.nb_addr  != 5'd0);
    assign div_acc = bus.div_valid & div_ready_int & (bus.div_addr != 5'd0);

    assign nb_flush_hit   = bus.flush_valid & (bus.flush_tid == bus.nb_tid);
    assign div_flush_hit  = bus.flush_valid & (bus.flush_tid == bus.div_tid);
    assign head_flush_hit = bus.flush_valid & (bus.flush_tid == ent_tid[rd_ptr]);

    // A head being flushed this cycle is treated as already dead: no write,
    // and it leaves the queue regardless of port_busy.
    assign head_eff  = ent_live[rd_ptr] & ~head_flush_hit;
    assign drain_wen = ~q_empty & head_eff & ~bus.port_busy;
    assign pop       = ~q_empty & (~head_eff | ~bus.port_busy);

`ifdef RV_GPR_WB_BYPASS_EN
    logic byp_ok;
    // nb has priority for the bypass slot; a simultaneous div is enqueued.
    assign byp_ok  = q_empty & ~bus.port_busy;
    assign byp_nb  = byp_ok & nb_acc & ~nb_flush_hit;
    assign byp_div = byp_ok & ~nb_acc & div_acc & ~div_flush_hit;
`else
    assign byp_nb  = 1'b0;
    assign byp_div = 1'b0;
`endif

    assign push_nb  = nb_acc  & ~byp_nb;
    assign push_div = div_acc & ~byp_div;

    // nb goes in first, div lands right behind it when both are pushed.
    assign nb_slot  = wr_ptr;
    assign div_slot = push_nb ? ptr_t'(wr_ptr + ptr_t'(1)) : wr_ptr;

    // Live bits and pointers. Flush clears matching entries, including ones
    // pushed this cycle (they are enqueued dead and popped silently later).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ent_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.flush_valid && (ent_tid[i] == bus.flush_tid)) begin
                    ent_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_live[rd_ptr] <= 1'b0;
            end
            if (push_nb) begin
                ent_live[nb_slot] <= ~nb_flush_hit;
            end
            if (push_div) begin
                ent_live[div_slot] <= ~div_flush_hit;
            end
            wr_ptr <= wr_ptr + ptr_t'(push_nb) + ptr_t'(push_div);
            rd_ptr <= rd_ptr + ptr_t'(pop);
            count  <= count + CNT_W'(push_nb) + CNT_W'(push_div) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; live bits qualify it.
    always_ff @(posedge clk) begin
        if (push_nb) begin
            ent_tid[nb_slot]  <= bus.nb_tid;
            ent_addr[nb_slot] <= bus.nb_addr;
            ent_data[nb_slot] <= bus.nb_data;
        end
        if (push_div) begin
            ent_tid[div_slot]  <= bus.div_tid;
            ent_addr[div_slot] <= bus.div_addr;
            ent_data[div_slot] <= bus.div_data;
        end
    end

    // Write port: head of queue, or a bypassed request when the queue is
    // empty (the two never coincide).
    always_comb begin
        wen_c   = drain_wen;
        wtid_c  = ent_tid[rd_ptr];
        waddr_c = ent_addr[rd_ptr];
        wd_c    = ent_data[rd_ptr];
        if (byp_nb) begin
            wen_c   = 1'b1;
            wtid_c  = bus.nb_tid;
            waddr_c = bus.nb_addr;
            wd_c    = bus.nb_data;
        end else if (byp_div) begin
            wen_c   = 1'b1;
            wtid_c  = bus.div_tid;
            waddr_c = bus.div_addr;
            wd_c    = bus.div_data;
        end
        if (rst) begin
            wen_c = 1'b0;
        end
    end

    // Pending masks: one-hot decode of every live entry, OR-ed per thread.
    always_comb begin
        pend0_c = '0;
        pend1_c = '0;
        for (int g = 1; g < 32; g++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_live[i] && (ent_addr[i] == 5'(g))) begin
                    if (ent_tid[i]) begin
                        pend1_c[g] = 1'b1;
                    end else begin
                        pend0_c[g] = 1'b1;
                    end
                end
            end
        end
        if (rst) begin
            pend0_c = '0;
            pend1_c = '0;
        end
    end

    assign bus.nb_ready  = nb_ready_int;
    assign bus.div_ready = div_ready_int;
    assign bus.wen       = wen_c;
    assign bus.wtid      = wtid_c;
    assign bus.waddr     = waddr_c;
    assign bus.wd        = wd_c;
    assign bus.pend_t0   = pend0_c;
    assign bus.pend_t1   = pend1_c;

`ifdef RV_ASSERT_ON
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !((push_nb | push_div) && (count == CNT_W'(DEPTH))));
`endif

endmodule
